// File: rtl/rgmii_mac_tx.sv
// Ethernet MAC transmit framer: preamble, SFD, payload, optional pad, CRC-32 FCS and inter-frame gap.
// Define MAC_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME_BYTES before the FCS.

module rgmii_mac_tx #(
  parameter int IFG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       clk_125mhz,
  input  logic       reset_n,
  input  logic [1:0] phy_speed_status,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic       s_axis_tready,
  output logic [7:0] tx_axis_rgmii_tdata,
  output logic       tx_axis_rgmii_tvalid,
  input  logic       tx_axis_rgmii_tready,
  output logic       tx_busy,
  output logic       tx_frame_done,
  output logic       tx_underflow
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_FCS  = 3'd5;
  localparam logic [2:0] ST_IFG  = 3'd6;
  localparam logic [2:0] ST_DROP = 3'd7;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [10:0] CNT_MAX  = 11'd2047;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);

`ifdef MAC_TX_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [10:0] ifg_clocks(input logic [1:0] speed);
    logic [10:0] n;
    case (speed)
      2'd0:    n = 11'(IFG_BYTES * 100);
      2'd1:    n = 11'(IFG_BYTES * 10);
      default: n = 11'(IFG_BYTES);
    endcase
    return n;
  endfunction

  logic [1:0]  speed_meta_r, speed_sync_r, speed_r;
  logic [2:0]  state_r;
  logic [7:0]  tdata_r;
  logic        tvalid_r;
  logic [31:0] crc_r;
  logic [10:0] byte_cnt_r;
  logic [2:0]  pre_cnt_r;
  logic [2:0]  fcs_cnt_r;
  logic [10:0] ifg_cnt_r;
  logic        tuser_r;
  logic        done_r;
  logic        underflow_r;

  logic        m_hs_s;
  logic        s_ready_s;
  logic [10:0] byte_cnt_inc_s;
  logic [31:0] crc_data_s;
  logic [31:0] fcs_word_s;
  logic [7:0]  fcs_byte_s;
  logic        pad_needed_s;
  logic [10:0] ifg_len_s;

  // Two-flop synchronizer for the asynchronous speed status.
  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      speed_meta_r <= 2'd0;
      speed_sync_r <= 2'd0;
    end else begin
      speed_meta_r <= phy_speed_status;
      speed_sync_r <= speed_meta_r;
    end
  end

  // Handshake decode, FCS byte selection and user-side ready.
  always_comb begin
    m_hs_s         = tvalid_r & tx_axis_rgmii_tready;
    byte_cnt_inc_s = (byte_cnt_r == CNT_MAX) ? CNT_MAX : (byte_cnt_r + 11'd1);
    crc_data_s     = crc32_byte(crc_r, s_axis_tdata);
    fcs_word_s     = tuser_r ? crc_r : ~crc_r;
    pad_needed_s   = PAD_EN & (byte_cnt_inc_s < MIN_CNT);
    ifg_len_s      = ifg_clocks(speed_r);
    case (fcs_cnt_r[1:0])
      2'd0:    fcs_byte_s = fcs_word_s[7:0];
      2'd1:    fcs_byte_s = fcs_word_s[15:8];
      2'd2:    fcs_byte_s = fcs_word_s[23:16];
      default: fcs_byte_s = fcs_word_s[31:24];
    endcase
    case (state_r)
      ST_SFD, ST_PAY: s_ready_s = tx_axis_rgmii_tready;
      ST_DROP:        s_ready_s = 1'b1;
      default:        s_ready_s = 1'b0;
    endcase
  end

  // Framing state machine; the output byte register only reloads on a consumer handshake.
  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      tdata_r     <= 8'h00;
      tvalid_r    <= 1'b0;
      crc_r       <= CRC_INIT;
      byte_cnt_r  <= 11'd0;
      pre_cnt_r   <= 3'd0;
      fcs_cnt_r   <= 3'd0;
      ifg_cnt_r   <= 11'd0;
      tuser_r     <= 1'b0;
      speed_r     <= 2'd0;
      done_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      underflow_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tvalid_r <= 1'b0;
          if (s_axis_tvalid) begin
            state_r    <= ST_PRE;
            tdata_r    <= 8'h55;
            tvalid_r   <= 1'b1;
            crc_r      <= CRC_INIT;
            byte_cnt_r <= 11'd0;
            pre_cnt_r  <= 3'd1;
            fcs_cnt_r  <= 3'd0;
            speed_r    <= speed_sync_r;
          end
        end
        ST_PRE: begin
          if (m_hs_s) begin
            if (pre_cnt_r < 3'd7) begin
              tdata_r   <= 8'h55;
              pre_cnt_r <= pre_cnt_r + 3'd1;
            end else begin
              tdata_r <= 8'hD5;
              state_r <= ST_SFD;
            end
          end
        end
        ST_SFD, ST_PAY: begin
          if (m_hs_s) begin
            if (s_axis_tvalid) begin
              tdata_r    <= s_axis_tdata;
              crc_r      <= crc_data_s;
              byte_cnt_r <= byte_cnt_inc_s;
              if (s_axis_tlast) begin
                tuser_r <= s_axis_tuser;
                state_r <= pad_needed_s ? ST_PAD : ST_FCS;
              end else begin
                state_r <= ST_PAY;
              end
            end else begin
              // Starved mid-frame: truncate on the wire and discard the rest of the frame.
              tvalid_r    <= 1'b0;
              underflow_r <= 1'b1;
              state_r     <= ST_DROP;
            end
          end
        end
`ifdef MAC_TX_PAD_EN
        ST_PAD: begin
          if (m_hs_s) begin
            tdata_r    <= 8'h00;
            crc_r      <= crc32_byte(crc_r, 8'h00);
            byte_cnt_r <= byte_cnt_inc_s;
            if (byte_cnt_inc_s >= MIN_CNT) begin
              state_r <= ST_FCS;
            end
          end
        end
`endif
        ST_FCS: begin
          if (m_hs_s) begin
            if (fcs_cnt_r < 3'd4) begin
              tdata_r   <= fcs_byte_s;
              fcs_cnt_r <= fcs_cnt_r + 3'd1;
            end else begin
              tvalid_r  <= 1'b0;
              done_r    <= 1'b1;
              ifg_cnt_r <= 11'd0;
              state_r   <= ST_IFG;
            end
          end
        end
        ST_IFG: begin
          tvalid_r <= 1'b0;
          if ((ifg_cnt_r + 11'd1) >= ifg_len_s) begin
            ifg_cnt_r <= 11'd0;
            state_r   <= ST_IDLE;
          end else begin
            ifg_cnt_r <= ifg_cnt_r + 11'd1;
          end
        end
        ST_DROP: begin
          tvalid_r <= 1'b0;
          if (s_axis_tvalid && s_axis_tlast) begin
            ifg_cnt_r <= 11'd0;
            state_r   <= ST_IFG;
          end
        end
        default: begin
          tvalid_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready        = s_ready_s;
  assign tx_axis_rgmii_tdata  = tdata_r;
  assign tx_axis_rgmii_tvalid = tvalid_r;
  assign tx_busy              = (state_r != ST_IDLE);
  assign tx_frame_done        = done_r;
  assign tx_underflow         = underflow_r;

endmodule

// File: tb/tb_rgmii_mac_tx.sv
// Directed self-checking bench for rgmii_mac_tx: wire bytes, FCS, pacing, IFG, underflow and reset.
// Pad expectations follow MAC_TX_PAD_EN in the same way as the design.

module tb_rgmii_mac_tx;

  logic       clk_125mhz = 1'b0;
  logic       reset_n;
  logic [1:0] phy_speed_status;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic       s_axis_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;
  logic       tx_busy;
  logic       tx_frame_done;
  logic       tx_underflow;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int rdy_cyc = 0;
  bit drv_timeout = 1'b0;

  logic [7:0] payload [0:255];
  logic [7:0] wire_q[$];
  logic [7:0] exp_q[$];
  int done_cnt = 0, unf_cnt = 0;
  int hi_run = 0, last_hi_run = 0, lo_run = 0, last_lo_run = 0;

  rgmii_mac_tx dut (
    .clk_125mhz           (clk_125mhz),
    .reset_n              (reset_n),
    .phy_speed_status     (phy_speed_status),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tready        (s_axis_tready),
    .tx_axis_rgmii_tdata  (tx_tdata),
    .tx_axis_rgmii_tvalid (tx_tvalid),
    .tx_axis_rgmii_tready (tx_tready),
    .tx_busy              (tx_busy),
    .tx_frame_done        (tx_frame_done),
    .tx_underflow         (tx_underflow)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  // Consumer ready: always high at 1000M, one pulse in ten at 100M.
  always @(posedge clk_125mhz) begin
    #1;
    rdy_cyc = rdy_cyc + 1;
    if (rdy_mode == 0) tx_tready = 1'b1;
    else               tx_tready = ((rdy_cyc % 10) == 0);
  end

  // Record handshaked bytes, pulses and tvalid run lengths.
  always @(negedge clk_125mhz) begin
    if (tx_tvalid && tx_tready) wire_q.push_back(tx_tdata);
    if (tx_frame_done) done_cnt++;
    if (tx_underflow) unf_cnt++;
    if (tx_tvalid) begin
      if (lo_run > 0) last_lo_run = lo_run;
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
      lo_run++;
    end
  end

  function automatic logic [31:0] sw_crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Append the expected wire image of one frame to exp_q.
  task automatic build_expected(input int start, input int len, input logic user);
    logic [31:0] crc;
    logic [31:0] fcs;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(payload[start + i]);
      crc = sw_crc_byte(crc, payload[start + i]);
    end
`ifdef MAC_TX_PAD_EN
    for (int i = len; i < 60; i++) begin
      exp_q.push_back(8'h00);
      crc = sw_crc_byte(crc, 8'h00);
    end
`endif
    fcs = user ? crc : ~crc;
    exp_q.push_back(fcs[7:0]);
    exp_q.push_back(fcs[15:8]);
    exp_q.push_back(fcs[23:16]);
    exp_q.push_back(fcs[31:24]);
  endtask

  // Present payload[start +: len]; optionally drop tvalid for one cycle before byte gap_at.
  task automatic drive_frame(input int start, input int len, input logic user, input int gap_at);
    bit acc;
    int t;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk_125mhz); #1;
      end
      s_axis_tdata  = payload[start + i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? user : 1'b0;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 5000) begin
        @(negedge clk_125mhz);
        acc = s_axis_tready;
        @(posedge clk_125mhz); #1;
        t++;
      end
      if (!acc) begin
        drv_timeout = 1'b1;
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int t;
    t = 0;
    while (done_cnt < target && t < 5000) begin
      @(negedge clk_125mhz);
      t++;
    end
    ok = (done_cnt >= target);
    repeat (2) @(negedge clk_125mhz);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_125mhz);
    checks++;
    if ({tx_tvalid, tx_tdata, s_axis_tready, tx_busy, tx_frame_done, tx_underflow} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%02h rdy=%b busy=%b done=%b unf=%b, required all 0",
               tx_tvalid, tx_tdata, s_axis_tready, tx_busy, tx_frame_done, tx_underflow);
    end
    reset_n = 1'b1;
    repeat (4) @(posedge clk_125mhz); #1;
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    wire_q.delete(); exp_q.delete();
    build_expected(0, 9, 1'b0);
    base = done_cnt;
    drv_timeout = 1'b0;
    drive_frame(0, 9, 1'b0, -1);
    wait_done(base + 1, ok);
    checks++;
    if (!ok || drv_timeout) begin errors++; $display("FAIL basic_timeout: done=%0d drv_to=%0d, required done %0d", done_cnt, drv_timeout, base + 1); end
    checks++;
    if (wire_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d bytes, required %0d", wire_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %02h, required %02h", i, wire_q[i], exp_q[i]); end
    end
    if (wire_q.size() >= 21) begin
      checks++;
      if ({wire_q[17], wire_q[18], wire_q[19], wire_q[20]} !== 32'h2639F4CB) begin
        errors++;
        $display("FAIL basic_fcs: got %02h %02h %02h %02h, required 26 39 f4 cb", wire_q[17], wire_q[18], wire_q[19], wire_q[20]);
      end
    end
    checks++;
    if (last_hi_run != 21) begin errors++; $display("FAIL basic_tvalid_run: got %0d cycles, required 21", last_hi_run); end
    checks++;
    if (done_cnt - base != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt - base); end
    checks++;
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_ifg: got %b, required 1", tx_busy); end
  endtask

  task automatic test_bad_fcs();
    int base;
    bit ok;
    wire_q.delete(); exp_q.delete();
    base = done_cnt;
    drv_timeout = 1'b0;
    drive_frame(0, 9, 1'b1, -1);
    wait_done(base + 1, ok);
    checks++;
    if (!ok || drv_timeout) begin errors++; $display("FAIL badfcs_timeout: done=%0d, required %0d", done_cnt, base + 1); end
    checks++;
    if (wire_q.size() != 21) begin errors++; $display("FAIL badfcs_len: got %0d bytes, required 21", wire_q.size()); end
    if (wire_q.size() >= 21) begin
      checks++;
      if ({wire_q[17], wire_q[18], wire_q[19], wire_q[20]} !== 32'hD9C60B34) begin
        errors++;
        $display("FAIL badfcs_fcs: got %02h %02h %02h %02h, required d9 c6 0b 34", wire_q[17], wire_q[18], wire_q[19], wire_q[20]);
      end
    end
    checks++;
    if (last_lo_run < 12 || last_lo_run > 13) begin errors++; $display("FAIL ifg_1000m: got %0d idle cycles, required 12..13", last_lo_run); end
    repeat (20) @(negedge clk_125mhz);
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", tx_busy); end
  endtask

  task automatic test_short();
    int base;
    bit ok;
    int exp_len;
`ifdef MAC_TX_PAD_EN
    exp_len = 72;
`else
    exp_len = 26;
`endif
    wire_q.delete(); exp_q.delete();
    build_expected(16, 14, 1'b0);
    base = done_cnt;
    drv_timeout = 1'b0;
    drive_frame(16, 14, 1'b0, -1);
    wait_done(base + 1, ok);
    checks++;
    if (!ok || drv_timeout) begin errors++; $display("FAIL short_timeout: done=%0d, required %0d", done_cnt, base + 1); end
    checks++;
    if (wire_q.size() != exp_len) begin errors++; $display("FAIL short_len: got %0d bytes, required %0d", wire_q.size(), exp_len); end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_byte[%0d]: got %02h, required %02h", i, wire_q[i], exp_q[i]); end
    end
    repeat (20) @(negedge clk_125mhz);
  endtask

  task automatic test_100m();
    int base;
    int t;
    logic stall_prev;
    logic [7:0] held;
    phy_speed_status = 2'd1;
    repeat (6) @(posedge clk_125mhz); #1;
    rdy_mode = 1;
    wire_q.delete(); exp_q.delete();
    build_expected(0, 9, 1'b0);
    build_expected(32, 5, 1'b0);
    base = done_cnt;
    drv_timeout = 1'b0;
    stall_prev = 1'b0;
    held = 8'h00;
    t = 0;
    fork
      begin
        drive_frame(0, 9, 1'b0, -1);
        drive_frame(32, 5, 1'b0, -1);
      end
    join_none
    while (done_cnt < base + 2 && t < 5000) begin
      @(negedge clk_125mhz);
      if (stall_prev && tx_tvalid) begin
        checks++;
        if (tx_tdata !== held) begin errors++; $display("FAIL hold_stable: got %02h, required %02h", tx_tdata, held); end
      end
      stall_prev = tx_tvalid & ~tx_tready;
      held = tx_tdata;
      t++;
    end
    repeat (2) @(negedge clk_125mhz);
    checks++;
    if (done_cnt < base + 2 || drv_timeout) begin errors++; $display("FAIL m100_timeout: done=%0d, required %0d", done_cnt, base + 2); end
    checks++;
    if (wire_q.size() != exp_q.size()) begin errors++; $display("FAIL m100_len: got %0d bytes, required %0d", wire_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL m100_byte[%0d]: got %02h, required %02h", i, wire_q[i], exp_q[i]); end
    end
    checks++;
    if (last_lo_run < 120 || last_lo_run > 121) begin errors++; $display("FAIL ifg_100m: got %0d idle cycles, required 120..121", last_lo_run); end
    rdy_mode = 0;
    phy_speed_status = 2'd2;
    repeat (150) @(posedge clk_125mhz); #1;
  endtask

  task automatic test_underflow();
    int base_u;
    int base_d;
    bit ok;
    wire_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 5; i++) exp_q.push_back(payload[64 + i]);
    base_u = unf_cnt;
    base_d = done_cnt;
    drv_timeout = 1'b0;
    drive_frame(64, 10, 1'b0, 5);
    repeat (3) @(negedge clk_125mhz);
    checks++;
    if (drv_timeout) begin errors++; $display("FAIL unf_drop_timeout: drop state did not absorb the frame, required tready=1"); end
    checks++;
    if (unf_cnt - base_u != 1) begin errors++; $display("FAIL unf_pulses: got %0d, required 1", unf_cnt - base_u); end
    checks++;
    if (done_cnt != base_d) begin errors++; $display("FAIL unf_done: got %0d pulses, required 0", done_cnt - base_d); end
    checks++;
    if (last_hi_run != 13) begin errors++; $display("FAIL unf_tvalid_run: got %0d, required 13", last_hi_run); end
    checks++;
    if (wire_q.size() != exp_q.size()) begin errors++; $display("FAIL unf_len: got %0d bytes, required %0d", wire_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL unf_byte[%0d]: got %02h, required %02h", i, wire_q[i], exp_q[i]); end
    end
    wire_q.delete(); exp_q.delete();
    build_expected(0, 9, 1'b0);
    base_d = done_cnt;
    drv_timeout = 1'b0;
    drive_frame(0, 9, 1'b0, -1);
    wait_done(base_d + 1, ok);
    checks++;
    if (!ok || drv_timeout) begin errors++; $display("FAIL unf_next_timeout: done=%0d, required %0d", done_cnt, base_d + 1); end
    checks++;
    if (wire_q.size() != exp_q.size()) begin errors++; $display("FAIL unf_next_len: got %0d, required %0d", wire_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL unf_next_byte[%0d]: got %02h, required %02h", i, wire_q[i], exp_q[i]); end
    end
    repeat (20) @(negedge clk_125mhz);
  endtask

  task automatic test_reset_mid();
    int t;
    int base;
    bit ok;
    wire_q.delete();
    drv_timeout = 1'b0;
    drive_frame(128, 60, 1'b0, -1);
    t = 0;
    while (wire_q.size() < 69 && t < 500) begin
      @(negedge clk_125mhz);
      t++;
    end
    checks++;
    if (wire_q.size() < 69 || drv_timeout) begin errors++; $display("FAIL rst_reach_fcs: got %0d bytes, required 69", wire_q.size()); end
    @(posedge clk_125mhz); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_tvalid !== 1'b0 || tx_tdata !== 8'h00) begin errors++; $display("FAIL rst_mid_tx: got v=%b d=%02h, required 0/00", tx_tvalid, tx_tdata); end
    checks++;
    if ({s_axis_tready, tx_busy, tx_frame_done, tx_underflow} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_flags: got rdy=%b busy=%b done=%b unf=%b, required 0", s_axis_tready, tx_busy, tx_frame_done, tx_underflow);
    end
    repeat (3) @(negedge clk_125mhz);
    reset_n = 1'b1;
    repeat (4) @(posedge clk_125mhz); #1;
    wire_q.delete(); exp_q.delete();
    build_expected(128, 60, 1'b0);
    base = done_cnt;
    drv_timeout = 1'b0;
    drive_frame(128, 60, 1'b0, -1);
    wait_done(base + 1, ok);
    checks++;
    if (!ok || drv_timeout) begin errors++; $display("FAIL rst_next_timeout: done=%0d, required %0d", done_cnt, base + 1); end
    checks++;
    if (wire_q.size() != 72) begin errors++; $display("FAIL rst_next_len: got %0d bytes, required 72", wire_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++) begin
      checks++;
      if (wire_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_next_byte[%0d]: got %02h, required %02h", i, wire_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    phy_speed_status = 2'd2;
    s_axis_tdata     = 8'h00;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = 1'b0;
    tx_tready        = 1'b1;
    for (int i = 0; i < 256; i++) payload[i] = 8'h00;
    for (int i = 0; i < 9; i++)   payload[i] = 8'(8'h31 + i);
    for (int i = 0; i < 14; i++)  payload[16 + i] = 8'(i + 1);
    for (int i = 0; i < 5; i++)   payload[32 + i] = 8'(8'hA0 + i);
    for (int i = 0; i < 10; i++)  payload[64 + i] = 8'(8'h10 + i);
    for (int i = 0; i < 60; i++)  payload[128 + i] = 8'(i * 7 + 3);

    test_reset();
    test_basic();
    test_bad_fcs();
    test_short();
    test_100m();
    test_underflow();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgmii_mac_tx.md
Name: rgmii_mac_tx

Overview:
- Ethernet MAC transmit framer, directly upstream of the RGMII transmit stage.
- Takes user frames as 8-bit AXI-Stream with tlast/tuser.
- Emits a continuous byte stream on tx_axis_rgmii_*: 7x preamble, SFD, payload, optional pad, CRC-32 FCS, then an inter-frame gap.
- Holds tvalid across a whole frame so the RGMII stage keeps TX_CTL asserted. It paces correctly at 1000 Mbps (tready always high) and at 10/100 Mbps (tready pulses once per byte).

Parameters:
- IFG_BYTES, 12: inter-frame gap length in byte times.
- MIN_FRAME_BYTES, 60: minimum payload+pad length before FCS (used only when padding is compiled in).

Ports:
- clk_125mhz  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- phy_speed_status  in  2  10M(0)/100M(1)/1000M(2); asynchronous; 2-FF synchronized internally.
- s_axis_tdata  in  8  user frame byte.
- s_axis_tvalid  in  1  user byte valid.
- s_axis_tlast  in  1  last payload byte of frame.
- s_axis_tuser  in  1  qualified with tlast; 1 = corrupt this frame's FCS.
- s_axis_tready  out  1  user byte accepted when tvalid & tready.
- tx_axis_rgmii_tdata  out  8  byte to RGMII stage.
- tx_axis_rgmii_tvalid  out  1  byte valid; high for the entire frame.
- tx_axis_rgmii_tready  in  1  RGMII stage accept.
- tx_busy  out  1  high in any state other than IDLE.
- tx_frame_done  out  1  1-cycle pulse when the last FCS byte handshakes.
- tx_underflow  out  1  1-cycle pulse when the user starves mid-payload.

Behaviour:
- Reset values: all outputs 0, tdata 0x00, state IDLE, CRC 0xFFFFFFFF, counters 0.
- Output register: one m-side byte register. A byte is consumed on tx_axis_rgmii_tvalid & tready. It may be reloaded in the same cycle it is consumed.
- Speed: the synchronized speed is latched in IDLE only, at frame start. Changes during a frame are ignored.
- States:
  - IDLE: tvalid=0, s_tready=0. When s_axis_tvalid=1 → PRE: load 0x55, CRC=0xFFFFFFFF, byte_cnt=0.
  - PRE: on each m handshake, load 0x55 until 7 preamble bytes have been sent, then load 0xD5 → SFD.
  - SFD: s_axis_tready = tx_axis_rgmii_tready. The SFD handshake simultaneously loads the first user byte → PAY.
  - PAY: s_axis_tready = tx_axis_rgmii_tready (1-cycle reload, no bubble). Each accepted byte updates CRC, and byte_cnt is incremented, saturating at 2047. On tlast acceptance: latch tuser → PAD or FCS.
  - PAD (only when MAC_TX_PAD_EN is defined): entered when byte_cnt < MIN_FRAME_BYTES. Load 0x00 bytes, updating CRC, until byte_cnt = MIN_FRAME_BYTES → FCS.
  - FCS: send ~CRC as 4 bytes, LSB byte first. If the latched tuser=1, send CRC without the final inversion (bad FCS). On the 4th handshake: tvalid=0, pulse tx_frame_done → IFG.
  - IFG: tvalid=0, s_tready=0. Wait IFG_BYTES × clocks-per-byte, where clocks-per-byte is 1 (1000M), 10 (100M), 100 (10M); 11-bit counter. Then → IDLE.
  - DROP: tvalid=0, s_tready=1. Discard bytes until a tlast is accepted → IFG.
- Underflow: in PAY, when the m handshake occurs with s_axis_tvalid=0:
  - drop tvalid, so the frame is truncated on the wire;
  - pulse tx_underflow;
  - → DROP, or → IFG if tlast was already consumed (cannot happen; defensive).
- CRC: CRC-32 IEEE, reflected polynomial 0xEDB88320, byte-wise update over payload + pad only. Preamble and SFD are excluded.
- tx_axis_rgmii_tdata must be stable while tvalid=1 & tready=0.
- Reset mid-frame: everything returns to reset values immediately, so tvalid drops asynchronously. The next frame starts fresh.
- Simultaneous events: in the FCS→IFG→IDLE path, a waiting s_axis_tvalid is not accepted before the IFG completes.

Optional Feature:
- Macro MAC_TX_PAD_EN.
- Defined: frames shorter than MIN_FRAME_BYTES are zero-padded before FCS, and the pad is included in CRC.
- Undefined: the PAD state is absent; FCS follows the last payload byte directly, for any length ≥ 1.

Test Plan:
- 1000M, tready=1, MAC_TX_PAD_EN undefined, payload ASCII "123456789", tuser=0 → wire bytes 55×7, D5, 31..39, 26 39 F4 CB. tvalid is high for exactly 21 consecutive cycles, then low ≥12 cycles; tx_frame_done pulses once.
- Same frame with tuser=1 on tlast → FCS bytes D9 C6 0B 34.
- MAC_TX_PAD_EN defined, 1000M, 14-byte payload → 60 payload+pad bytes (46 zeros), 72 bytes on the wire; FCS matches a software CRC of the padded data.
- 100M, tready pulsing 1 cycle in 10 → each byte held until its pulse; no byte is skipped or duplicated. IFG = 120 clocks of tvalid=0 before the next preamble.
- Underflow: 1000M, s_axis_tvalid dropped for 1 cycle at payload byte 5 → tvalid falls, tx_underflow pulses once. The remaining bytes through tlast are absorbed with s_tready=1, followed by IFG and then a clean next frame.
- Assert reset_n low during FCS → all outputs 0 immediately. After release, a new 60-byte frame transmits correctly.
